// File: rtl/imem_fetch.sv
// Instruction memory fetch stage: single-entry response buffer in front of a
// word-addressed instruction RAM with a program-load port, flush and
// saturating fetch/error counters.
module imem_fetch #(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          DEPTH     = 256,
    parameter logic [DATA_W-1:0]    NOP_INSTR = 32'h00000013
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_W-1:0]           req_addr,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_instr,
    output logic [ADDR_W-1:0]           rsp_addr,
    output logic                        rsp_err,
    input  logic                        flush,
    input  logic                        load_en,
    input  logic [$clog2(DEPTH)-1:0]    load_addr,
    input  logic [DATA_W-1:0]           load_data,
    output logic [31:0]                 fetch_cnt,
    output logic [31:0]                 err_cnt
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                 state_q;
    logic                   rdy_en_q;
    logic [DATA_W-1:0]      rsp_instr_q;
    logic [ADDR_W-1:0]      rsp_addr_q;
    logic                   rsp_err_q;
    logic [31:0]            fetch_cnt_q;
    logic [31:0]            err_cnt_q;

    logic [DATA_W-1:0]      mem [DEPTH];

    logic                   req_fire;
    logic                   rsp_fire;
    logic [IDX_W-1:0]       rd_idx;
    logic [ADDR_W-1:0]      addr_hi;
    logic                   addr_bad;
    logic [DATA_W-1:0]      rd_data;
    logic [DATA_W-1:0]      rsp_instr_d;

    // Request decode: word index, range/alignment check, write-first read
    always_comb begin
        rd_idx   = req_addr[IDX_W+1:2];
        addr_hi  = req_addr >> (IDX_W + 2);
        addr_bad = (req_addr[1:0] != 2'b00) || (addr_hi != '0);
        rd_data  = (load_en && (load_addr == rd_idx)) ? load_data : mem[rd_idx];
        rsp_instr_d = addr_bad ? NOP_INSTR : rd_data;
    end

    // Ready is held low through reset and for the cycle a flush is applied
    assign req_ready = rdy_en_q && ((state_q == EMPTY) || rsp_ready) && !flush;
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = (state_q == FULL) && rsp_ready;

    // Program-load port; the array itself has no reset
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Response buffer FSM, ready release and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            rdy_en_q    <= 1'b0;
            rsp_instr_q <= NOP_INSTR;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
            fetch_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (flush) begin
                // Held response is dropped uncounted; no request can fire
                state_q <= EMPTY;
            end else begin
                if (rsp_fire) begin
                    if (fetch_cnt_q != CNT_MAX) begin
                        fetch_cnt_q <= fetch_cnt_q + 32'd1;
                    end
                    if (rsp_err_q && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_q <= err_cnt_q + 32'd1;
                    end
                end
                if (req_fire) begin
                    state_q     <= FULL;
                    rsp_instr_q <= rsp_instr_d;
                    rsp_addr_q  <= req_addr;
                    rsp_err_q   <= addr_bad;
                end else if (rsp_fire) begin
                    state_q <= EMPTY;
                end
            end
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_instr = rsp_instr_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;
    assign fetch_cnt = fetch_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: vector table for streaming, errors and
// write-first reads, plus hand sequences for stall, flush and mid-stream reset.
module tb_imem_fetch;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        flush;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] fetch_cnt;
    logic [31:0] err_cnt;

    int n_checks;
    int n_fail;

    imem_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .fetch_cnt (fetch_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        le;
        logic [7:0]  la;
        logic [31:0] ld;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ea;
        logic        ee;
        logic [31:0] efc;
        logic [31:0] eec;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic rv, logic [31:0] ra, logic le, logic [7:0] la,
                                logic [31:0] ld, logic ev, logic [31:0] ei,
                                logic [31:0] ea, logic ee, logic [31:0] efc,
                                logic [31:0] eec);
        vec_t v;
        v.rv = rv; v.ra = ra; v.le = le; v.la = la; v.ld = ld;
        v.ev = ev; v.ei = ei; v.ea = ea; v.ee = ee; v.efc = efc; v.eec = eec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        //            rv  ra            le la     ld            ev ei            ea            ee efc eec
        vecs[0]  = mk(0, 32'h0,        1, 8'd0,   32'h00500093, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[1]  = mk(0, 32'h0,        1, 8'd1,   32'h00A00113, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[2]  = mk(0, 32'h0,        1, 8'd2,   32'h002081B3, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[3]  = mk(0, 32'h0,        1, 8'd3,   32'h00000013, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[4]  = mk(1, 32'h0,        0, 8'd0,   32'h0,        1, 32'h00500093, 32'h0,        0, 0, 0);
        vecs[5]  = mk(1, 32'h4,        0, 8'd0,   32'h0,        1, 32'h00A00113, 32'h4,        0, 1, 0);
        vecs[6]  = mk(1, 32'h8,        0, 8'd0,   32'h0,        1, 32'h002081B3, 32'h8,        0, 2, 0);
        vecs[7]  = mk(1, 32'hC,        0, 8'd0,   32'h0,        1, 32'h00000013, 32'hC,        0, 3, 0);
        vecs[8]  = mk(0, 32'h0,        0, 8'd0,   32'h0,        0, 32'h0,        32'h0,        0, 4, 0);
        vecs[9]  = mk(1, 32'h6,        0, 8'd0,   32'h0,        1, 32'h00000013, 32'h6,        1, 4, 0);
        vecs[10] = mk(1, 32'h400,      0, 8'd0,   32'h0,        1, 32'h00000013, 32'h400,      1, 5, 1);
        vecs[11] = mk(0, 32'h0,        0, 8'd0,   32'h0,        0, 32'h0,        32'h0,        0, 6, 2);
        vecs[12] = mk(1, 32'h8,        1, 8'd2,   32'hDEADBEEF, 1, 32'hDEADBEEF, 32'h8,        0, 6, 2);
        vecs[13] = mk(0, 32'h0,        1, 8'd255, 32'hCAFEF00D, 0, 32'h0,        32'h0,        0, 7, 2);
        vecs[14] = mk(1, 32'h3FC,      0, 8'd0,   32'h0,        1, 32'hCAFEF00D, 32'h3FC,      0, 7, 2);
        vecs[15] = mk(1, 32'h2,        0, 8'd0,   32'h0,        1, 32'h00000013, 32'h2,        1, 8, 2);
        vecs[16] = mk(0, 32'h0,        0, 8'd0,   32'h0,        0, 32'h0,        32'h0,        0, 9, 3);

        // Reset state
        tick();
        tick();
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_instr", rsp_instr, 32'h00000013);
        chk("reset rsp_addr",  rsp_addr, 32'h0);
        chk("reset rsp_err",   32'(rsp_err), 32'h0);
        chk("reset fetch_cnt", fetch_cnt, 32'h0);
        chk("reset err_cnt",   err_cnt, 32'h0);
        chk("reset req_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("req_ready before first edge", 32'(req_ready), 32'h0);

        // Table-driven vectors, consumer always ready
        rsp_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            req_valid = vecs[i].rv;
            req_addr  = vecs[i].ra;
            load_en   = vecs[i].le;
            load_addr = vecs[i].la;
            load_data = vecs[i].ld;
            tick();
            chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'h1);
            chk($sformatf("v%0d fetch_cnt", i), fetch_cnt, vecs[i].efc);
            chk($sformatf("v%0d err_cnt", i), err_cnt, vecs[i].eec);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d rsp_instr", i), rsp_instr, vecs[i].ei);
                chk($sformatf("v%0d rsp_addr", i), rsp_addr, vecs[i].ea);
                chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].ee));
            end
        end
        req_valid = 1'b0;
        load_en   = 1'b0;

        // Stall: response held while consumer is not ready
        req_valid = 1'b1;
        req_addr  = 32'h4;
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        held = rsp_instr;
        chk("stall first rsp_instr", held, 32'h00A00113);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d rsp_valid", c), 32'(rsp_valid), 32'h1);
            chk($sformatf("stall%0d rsp_instr", c), rsp_instr, 32'h00A00113);
            chk($sformatf("stall%0d rsp_addr", c), rsp_addr, 32'h4);
            chk($sformatf("stall%0d req_ready", c), 32'(req_ready), 32'h0);
            chk($sformatf("stall%0d fetch_cnt", c), fetch_cnt, 32'd9);
        end
        rsp_ready = 1'b1;
        #1;
        chk("stall release req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("stall done rsp_valid", 32'(rsp_valid), 32'h0);
        chk("stall done fetch_cnt", fetch_cnt, 32'd10);

        // Flush: beats both rsp_ready and a pending request
        req_valid = 1'b1;
        req_addr  = 32'h0;
        rsp_ready = 1'b0;
        tick();
        chk("pre-flush rsp_valid", 32'(rsp_valid), 32'h1);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        #1;
        chk("flush req_ready", 32'(req_ready), 32'h0);
        tick();
        chk("flush rsp_valid", 32'(rsp_valid), 32'h0);
        chk("flush fetch_cnt", fetch_cnt, 32'd10);
        flush     = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("post-flush rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post-flush fetch_cnt", fetch_cnt, 32'd10);

        // Reset asserted mid-stream
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        chk("stream rsp_valid", 32'(rsp_valid), 32'h1);
        chk("stream fetch_cnt", fetch_cnt, 32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst fetch_cnt", fetch_cnt, 32'h0);
        chk("midrst err_cnt", err_cnt, 32'h0);
        chk("midrst rsp_instr", rsp_instr, 32'h00000013);
        chk("midrst req_ready", 32'(req_ready), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        req_addr = 32'h0;
        #1;
        chk("post-rst req_ready low", 32'(req_ready), 32'h0);
        tick();
        chk("post-rst no fetch", 32'(rsp_valid), 32'h0);
        chk("post-rst req_ready high", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        chk("refetch rsp_valid", 32'(rsp_valid), 32'h1);
        chk("refetch rsp_instr", rsp_instr, 32'h00500093);
        chk("refetch fetch_cnt", fetch_cnt, 32'h0);
        tick();
        chk("refetch done rsp_valid", 32'(rsp_valid), 32'h0);
        chk("refetch done fetch_cnt", fetch_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 256, number of words; a power of two, at least 2.
REQ-004 SHALL have parameter NOP_INSTR, default 32'h00000013, word returned on error or reset.
REQ-005 SHALL have ports: clk  input  1  single clock, rising-edge.
REQ-006 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: req_valid  input  1  fetch request valid.
REQ-008 SHALL have ports: req_ready  output  1  request accepted when high with req_valid.
REQ-009 SHALL have ports: req_addr  input  ADDR_W  byte address of the fetch.
REQ-010 SHALL have ports: rsp_valid  output  1  response valid.
REQ-011 SHALL have ports: rsp_ready  input  1  consumer accepts the response.
REQ-012 SHALL have ports: rsp_instr  output  DATA_W  fetched instruction.
REQ-013 SHALL have ports: rsp_addr  output  ADDR_W  address echoed from the request.
REQ-014 SHALL have ports: rsp_err  output  1  misaligned or out-of-range request.
REQ-015 SHALL have ports: flush  input  1  discard the pending response.
REQ-016 SHALL have ports: load_en, load_addr (word index, log2(DEPTH) bits), load_data (DATA_W)  inputs  program-write port.
REQ-017 SHALL have ports: fetch_cnt, err_cnt  outputs  32 each  saturating counters of completed responses and error responses.

Function
REQ-018 SHALL complete a request when req_valid and req_ready are both high on a rising edge.
REQ-019 SHALL use a two-state machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-020 SHALL go EMPTY->FULL when a request completes, and stay EMPTY otherwise.
REQ-021 SHALL go FULL->EMPTY when rsp_ready=1 and no new request completes.
REQ-022 SHALL stay FULL and reload rsp_* on the same edge when rsp_ready=1 and a new request completes (back-to-back, one response per cycle).
REQ-023 SHALL stay FULL with rsp_instr, rsp_addr and rsp_err held stable while rsp_ready=0.
REQ-024 SHALL drive req_ready = !rsp_valid || rsp_ready, gated low while flush=1.
REQ-025 SHALL present the response exactly one cycle after the request completes.
REQ-026 SHALL read mem[req_addr[log2(DEPTH)+1:2]].
REQ-027 SHALL set rsp_err=1 and rsp_instr=NOP_INSTR when req_addr[1:0]!=0 or req_addr>=DEPTH*4.
REQ-028 SHALL write load_data into mem[load_addr] on the edge when load_en=1.
REQ-029 SHALL be write-first: a read of the same word on the same edge as a write returns load_data.
REQ-030 SHALL, on flush=1, go to EMPTY on the next edge, drop the held response, and count nothing for it.
REQ-031 SHALL give flush priority over rsp_ready and over any request completion.
REQ-032 SHALL increment fetch_cnt on each rsp_valid && rsp_ready edge, and err_cnt on those edges where rsp_err=1.
REQ-033 SHALL hold both counters at 32'hFFFFFFFF once saturated.
REQ-034 SHALL keep the memory array out of reset; its contents are defined only by load writes.

Reset
REQ-035 SHALL, asynchronously on rst_n=0, force EMPTY, rsp_valid=0, rsp_instr=NOP_INSTR, rsp_addr=0, rsp_err=0, fetch_cnt=0 and err_cnt=0.
REQ-036 SHALL hold req_ready=0 while rst_n=0 and release it on the first edge after rst_n rises.
REQ-037 SHALL discard an in-flight response when reset is asserted mid-operation; memory contents are retained.

Verification
REQ-038 SHALL pass: load mem[0..3]=00500093, 00A00113, 002081B3, 00000013; request 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 -> those four words returned on consecutive cycles, one cycle late, fetch_cnt=4.
REQ-039 SHALL pass: request 0x4 with rsp_ready=0 for 3 cycles -> rsp_instr=00A00113 held stable, req_ready=0; then rsp_ready=1 -> one handshake, fetch_cnt+1.
REQ-040 SHALL pass: request 0x6 and 0x400 (DEPTH=256) -> rsp_err=1, rsp_instr=00000013, err_cnt=2.
REQ-041 SHALL pass: load_en with load_addr=2, data DEADBEEF, and a request for 0x8 on the same edge -> rsp_instr=DEADBEEF.
REQ-042 SHALL pass: FULL with rsp_ready=0, then flush=1 for one cycle -> rsp_valid=0 on the next edge, fetch_cnt unchanged, req_ready=0 during the flush cycle.
REQ-043 SHALL pass: rst_n pulsed low mid-stream -> rsp_valid=0 and counters=0 immediately; a refetch of 0x0 returns the preloaded 00500093.
